// File: rtl/stage_mem_lsu_pkg.sv
// Shared constants, types and helpers for the MEM-stage load/store unit:
// opcode/funct3 encodings, FSM states, alignment check, lane steering, load extension.
package stage_mem_lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } lsu_state_t;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lane;
    } load_ctx_t;

    // Illegal size encodings and naturally-misaligned H/W accesses are refused.
    function automatic logic access_rejected(input logic [2:0] funct3, input logic [1:0] lane);
        if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
            return 1'b1;
        end
        case (funct3[1:0])
            2'b01:   return lane[0];
            2'b10:   return (lane != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input load_ctx_t ctx, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*ctx.lane +: 8];
        h = ctx.lane[1] ? word[31:16] : word[15:0];
        case (ctx.funct3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LBU:  return {24'd0, b};
            F3_LHU:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_lsu_dmem_bytewise.sv
// Word-organised data RAM: synchronous write with per-byte enables, synchronous registered read.
module dmem_bytewise #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        // rdata only moves on a read so a completed load keeps presenting its word
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM pipeline stage: byte/half/word loads and stores against a wait-state data RAM,
// stall handshake toward upstream, pass-through of non-memory results.
module stage_mem_lsu
    import stage_mem_lsu_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int WAIT_STATES     = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            EX_MEM_valid,
    input  logic            EX_MEM_mem_read_en,
    input  logic            EX_MEM_mem_write_en,
    input  logic [6:0]      EX_MEM_inst_opcode,
    input  logic [2:0]      EX_MEM_funct3,
    input  logic [XLEN-1:0] EX_MEM_alu_out,
    input  logic [XLEN-1:0] EX_MEM_dataB,
    output logic            MEM_stall,
    output logic            MEM_data_valid,
    output logic [XLEN-1:0] MEM_data_out,
    output logic            MEM_misaligned
);

    localparam int WORD_AW = DMEM_ADDR_WIDTH - 2;
    // BUSY is entered one cycle after acceptance, so the count starts one lower.
    localparam logic [3:0] BUSY_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    lsu_state_t       state, state_nxt;
    logic [3:0]       wait_cnt, wait_cnt_nxt;
    logic             req, rejected, accepted, complete;
    logic [1:0]       lane, size;
    logic             ram_we, ram_re;
    logic [3:0]       ram_be;
    logic [31:0]      ram_wdata, ram_rdata;
    logic [WORD_AW-1:0] ram_addr;
    logic [XLEN-1:0]  result_q;
    logic             load_sel_q;
    load_ctx_t        load_ctx_q;

    assign lane     = EX_MEM_alu_out[1:0];
    assign size     = EX_MEM_funct3[1:0];
    assign req      = EX_MEM_valid & (EX_MEM_mem_read_en | EX_MEM_mem_write_en);
    assign rejected = access_rejected(EX_MEM_funct3, lane);
    assign accepted = req & ~rejected;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        MEM_stall    = 1'b0;
        complete     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accepted) begin
                    if (WAIT_STATES == 0) begin
                        complete = 1'b1;
                    end else begin
                        MEM_stall    = 1'b1;
                        wait_cnt_nxt = BUSY_CNT_INIT;
                        state_nxt    = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                MEM_stall = 1'b1;
                if (wait_cnt == 4'd0) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
        endcase
    end

    // A reset sampled on the commit edge must not let the store land.
    assign ram_we    = complete & EX_MEM_mem_write_en & ~reset;
    assign ram_re    = complete & EX_MEM_mem_read_en & ~reset;
    assign ram_be    = byte_enable(size, lane);
    assign ram_wdata = store_lanes(size, EX_MEM_dataB[31:0]);
    assign ram_addr  = EX_MEM_alu_out[DMEM_ADDR_WIDTH-1:2];

    dmem_bytewise #(
        .ADDR_WIDTH(WORD_AW)
    ) u_dmem (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            MEM_data_valid <= 1'b0;
            MEM_misaligned <= 1'b0;
            result_q       <= '0;
            load_sel_q     <= 1'b0;
            load_ctx_q     <= '0;
        end else begin
            state          <= state_nxt;
            wait_cnt       <= wait_cnt_nxt;
            MEM_data_valid <= 1'b0;
            MEM_misaligned <= 1'b0;
            if (state == ST_IDLE && EX_MEM_valid && !req) begin
                MEM_data_valid <= 1'b1;
                result_q       <= EX_MEM_alu_out;
                load_sel_q     <= 1'b0;
            end
            if (state == ST_IDLE && req && rejected) begin
                MEM_misaligned <= 1'b1;
            end
            if (complete) begin
                MEM_data_valid <= 1'b1;
                if (EX_MEM_mem_read_en) begin
                    load_sel_q        <= 1'b1;
                    load_ctx_q.funct3 <= EX_MEM_funct3;
                    load_ctx_q.lane   <= lane;
                end else begin
                    load_sel_q <= 1'b0;
                    result_q   <= EX_MEM_alu_out;
                end
            end
        end
    end

    // The RAM output register doubles as the load result register; extension sits after it
    // so load data still appears one cycle after the last stall cycle.
    assign MEM_data_out = load_sel_q ? XLEN'(extend_load(load_ctx_q, ram_rdata)) : result_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (XLEN == 32);
            assert (WAIT_STATES >= 0 && WAIT_STATES <= 15);
            assert (!(EX_MEM_valid && EX_MEM_mem_read_en && EX_MEM_mem_write_en));
            assert (!(EX_MEM_valid && EX_MEM_mem_read_en && EX_MEM_inst_opcode != OPC_LOAD));
            assert (!(EX_MEM_valid && EX_MEM_mem_write_en && EX_MEM_inst_opcode != OPC_STORE));
        end
    end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Self-checking bench for stage_mem_lsu: three instances (WAIT_STATES 1, 3, 0), directed
// vector table, reset-abort sequences and randomized traffic against a byte-array model.
module tb_stage_mem_lsu;

    localparam int NI = 3;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst [NI];
    logic        v   [NI];
    logic        rd  [NI];
    logic        wr  [NI];
    logic [6:0]  opc [NI];
    logic [2:0]  f3  [NI];
    logic [31:0] adr [NI];
    logic [31:0] dat [NI];
    logic        stall [NI];
    logic        dv    [NI];
    logic        mis   [NI];
    logic [31:0] dout  [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        stage_mem_lsu #(
            .XLEN            (32),
            .DMEM_ADDR_WIDTH (12),
            .WAIT_STATES     ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk                 (clk),
            .reset               (rst[g]),
            .EX_MEM_valid        (v[g]),
            .EX_MEM_mem_read_en  (rd[g]),
            .EX_MEM_mem_write_en (wr[g]),
            .EX_MEM_inst_opcode  (opc[g]),
            .EX_MEM_funct3       (f3[g]),
            .EX_MEM_alu_out      (adr[g]),
            .EX_MEM_dataB        (dat[g]),
            .MEM_stall           (stall[g]),
            .MEM_data_valid      (dv[g]),
            .MEM_data_out        (dout[g]),
            .MEM_misaligned      (mis[g])
        );
    end

    function automatic int ws(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
    endfunction

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0]  mem_m [NI][4096];
    logic        p_dv  [NI];
    logic        p_mis [NI];
    logic        p_chk [NI];
    logic [31:0] p_dout[NI];
    logic [31:0] last  [NI];
    bit          known [NI];

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, i, $time, act, exp);
        end
    endtask

    task automatic check_pending(input int i);
        check("data_valid", i, 32'(dv[i]), 32'(p_dv[i]));
        check("misaligned", i, 32'(mis[i]), 32'(p_mis[i]));
        if (p_chk[i]) check("data_out", i, dout[i], p_dout[i]);
    endtask

    // Drive one op; results of the previous op on this instance are visible in this cycle.
    task automatic issue(input int i, input logic vv, input logic rr, input logic ww,
                         input logic [6:0] op, input logic [2:0] ff, input logic [31:0] aa,
                         input logic [31:0] dd, input logic e_stall, input logic e_dv,
                         input logic e_mis, input logic e_chk, input logic [31:0] e_dout);
        int hold;
        @(negedge clk);
        v[i] = vv; rd[i] = rr; wr[i] = ww; opc[i] = op; f3[i] = ff; adr[i] = aa; dat[i] = dd;
        #1;
        check_pending(i);
        check("stall_first", i, 32'(stall[i]), 32'(e_stall));
        hold = e_stall ? ws(i) + 1 : 1;
        for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            #1;
            check("stall_hold", i, 32'(stall[i]), 32'd1);
            check("valid_in_stall", i, 32'(dv[i]), 32'd0);
            check("mis_in_stall", i, 32'(mis[i]), 32'd0);
        end
        p_dv[i] = e_dv; p_mis[i] = e_mis; p_chk[i] = e_chk; p_dout[i] = e_dout;
    endtask

    // Reference behaviour from the access rules, on a flat byte array.
    task automatic model_op(input int i, input logic vv, input logic rr, input logic ww,
                            input logic [2:0] ff, input logic [31:0] aa, input logic [31:0] dd,
                            output logic e_stall, output logic e_dv, output logic e_mis,
                            output logic e_chk, output logic [31:0] e_dout);
        bit     req, rej, illegal;
        int     size, nb, off, base;
        longint val;
        req     = vv && (rr || ww);
        size    = int'(ff) % 4;
        nb      = 1 << size;
        off     = int'(aa % 4);
        base    = int'(aa % 4096);
        illegal = (ff == 3) || (ff == 6) || (ff == 7);
        rej     = req && (illegal || (size == 1 && off % 2 != 0) || (size == 2 && off != 0));
        e_stall = req && !rej && ws(i) > 0;
        e_mis   = rej;
        e_dv    = vv && !rej;
        e_dout  = aa;
        e_chk   = 1'b1;
        if (!vv) begin
            e_dout = last[i];
            e_chk  = known[i];
        end else if (rej) begin
            e_chk    = 1'b0;
            known[i] = 1'b0;
        end else begin
            if (req && ww) begin
                for (int b = 0; b < nb; b++) mem_m[i][base + b] = 8'(dd >> (8 * b));
            end
            if (req && rr) begin
                val = 0;
                for (int b = 0; b < nb; b++) val = val + (longint'(mem_m[i][base + b]) << (8 * b));
                if (ff < 4 && val >= (longint'(1) << (8 * nb - 1))) val = val - (longint'(1) << (8 * nb));
                e_dout = 32'(val);
            end
            last[i]  = e_dout;
            known[i] = 1'b1;
        end
    endtask

    task automatic do_op(input int i, input logic vv, input logic rr, input logic ww,
                         input logic [6:0] op, input logic [2:0] ff, input logic [31:0] aa,
                         input logic [31:0] dd);
        logic es, edv, emis, echk;
        logic [31:0] ed;
        model_op(i, vv, rr, ww, ff, aa, dd, es, edv, emis, echk, ed);
        issue(i, vv, rr, ww, op, ff, aa, dd, es, edv, emis, echk, ed);
    endtask

    task automatic idle(input int i);
        do_op(i, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 32'd0, 32'd0);
    endtask

    typedef struct {
        int          inst;
        logic        vv, rr, ww;
        logic [6:0]  op;
        logic [2:0]  ff;
        logic [31:0] aa, dd;
        logic        e_stall, e_dv, e_mis, e_chk;
        logic [31:0] e_dout;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input int inst, input logic vv, input logic rr, input logic ww,
                                input logic [6:0] op, input logic [2:0] ff, input logic [31:0] aa,
                                input logic [31:0] dd, input logic es, input logic edv,
                                input logic emis, input logic echk, input logic [31:0] ed);
        vec_t t;
        t.inst = inst; t.vv = vv; t.rr = rr; t.ww = ww; t.op = op; t.ff = ff; t.aa = aa; t.dd = dd;
        t.e_stall = es; t.e_dv = edv; t.e_mis = emis; t.e_chk = echk; t.e_dout = ed;
        return t;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic es, edv, emis, echk;
        logic [31:0] ed;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; v[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
            opc[i] = '0; f3[i] = '0; adr[i] = '0; dat[i] = '0;
            p_dv[i] = 1'b0; p_mis[i] = 1'b0; p_chk[i] = 1'b1; p_dout[i] = '0;
            last[i] = '0; known[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("reset_stall", i, 32'(stall[i]), 32'd0);
            check("reset_valid", i, 32'(dv[i]), 32'd0);
            check("reset_mis", i, 32'(mis[i]), 32'd0);
            check("reset_dout", i, dout[i], 32'd0);
        end

        // known contents for the small window used by every test
        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < 16; w++) do_op(i, 1'b1, 1'b0, 1'b1, OP_STORE, 3'b010, 32'(4 * w), 32'd0);
            idle(i);
        end

        tab.push_back(mk(0, 1, 0, 1, OP_STORE, 3'b010, 32'h10, 32'hDEADBEEF, 1, 1, 0, 1, 32'h10));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b010, 32'h10, 32'h0, 1, 1, 0, 1, 32'hDEADBEEF));
        tab.push_back(mk(0, 1, 0, 1, OP_STORE, 3'b000, 32'h13, 32'h80, 1, 1, 0, 1, 32'h13));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b000, 32'h13, 32'h0, 1, 1, 0, 1, 32'hFFFFFF80));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b100, 32'h13, 32'h0, 1, 1, 0, 1, 32'h00000080));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b010, 32'h10, 32'h0, 1, 1, 0, 1, 32'h80ADBEEF));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b001, 32'h11, 32'h0, 0, 0, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b010, 32'h10, 32'h0, 1, 1, 0, 1, 32'h80ADBEEF));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b011, 32'h10, 32'h0, 0, 0, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 0, 0, OP_JAL,   3'b000, 32'h104, 32'h0, 0, 1, 0, 1, 32'h104));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b101, 32'h12, 32'h0, 1, 1, 0, 1, 32'h000080AD));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b001, 32'h12, 32'h0, 1, 1, 0, 1, 32'hFFFF80AD));
        tab.push_back(mk(0, 1, 0, 1, OP_STORE, 3'b001, 32'h16, 32'h1234ABCD, 1, 1, 0, 1, 32'h16));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b010, 32'h14, 32'h0, 1, 1, 0, 1, 32'hABCD0000));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b010, 32'h7FFFF010, 32'h0, 1, 1, 0, 1, 32'h80ADBEEF));
        tab.push_back(mk(0, 1, 0, 1, OP_STORE, 3'b010, 32'h12, 32'h11223344, 0, 0, 1, 0, 32'h0));
        tab.push_back(mk(0, 1, 1, 0, OP_LOAD,  3'b010, 32'h10, 32'h0, 1, 1, 0, 1, 32'h80ADBEEF));
        tab.push_back(mk(0, 0, 0, 0, 7'd0,     3'b000, 32'h55, 32'h0, 0, 0, 0, 1, 32'h80ADBEEF));
        tab.push_back(mk(0, 0, 1, 0, OP_LOAD,  3'b010, 32'h20, 32'h0, 0, 0, 0, 1, 32'h80ADBEEF));
        tab.push_back(mk(2, 1, 0, 1, OP_STORE, 3'b010, 32'h30, 32'hCAFEF00D, 0, 1, 0, 1, 32'h30));
        tab.push_back(mk(2, 1, 1, 0, OP_LOAD,  3'b010, 32'h30, 32'h0, 0, 1, 0, 1, 32'hCAFEF00D));
        tab.push_back(mk(2, 1, 0, 1, OP_STORE, 3'b000, 32'h31, 32'h55, 0, 1, 0, 1, 32'h31));
        tab.push_back(mk(2, 1, 1, 0, OP_LOAD,  3'b101, 32'h30, 32'h0, 0, 1, 0, 1, 32'h0000550D));
        tab.push_back(mk(2, 1, 1, 0, OP_LOAD,  3'b000, 32'h33, 32'h0, 0, 1, 0, 1, 32'hFFFFFFCA));
        tab.push_back(mk(2, 0, 0, 0, 7'd0,     3'b000, 32'h0, 32'h0, 0, 0, 0, 1, 32'hFFFFFFCA));

        foreach (tab[n]) begin
            model_op(tab[n].inst, tab[n].vv, tab[n].rr, tab[n].ww, tab[n].ff, tab[n].aa, tab[n].dd,
                     es, edv, emis, echk, ed);
            issue(tab[n].inst, tab[n].vv, tab[n].rr, tab[n].ww, tab[n].op, tab[n].ff, tab[n].aa,
                  tab[n].dd, tab[n].e_stall, tab[n].e_dv, tab[n].e_mis, tab[n].e_chk, tab[n].e_dout);
        end

        // reset while BUSY (WAIT_STATES=3): once early, once on the commit cycle
        do_op(1, 1'b1, 1'b0, 1'b1, OP_STORE, 3'b010, 32'h20, 32'hA5A50F0F);
        idle(1);
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            v[1] = 1'b1; rd[1] = 1'b0; wr[1] = 1'b1; opc[1] = OP_STORE; f3[1] = 3'b010;
            adr[1] = 32'h20; dat[1] = (pass == 0) ? 32'h12345678 : 32'hFFFF0000;
            #1;
            check_pending(1);
            check("abort_stall", 1, 32'(stall[1]), 32'd1);
            for (int k = 0; k < ((pass == 0) ? 1 : 3); k++) begin
                @(negedge clk);
                #1;
                check("abort_stall_hold", 1, 32'(stall[1]), 32'd1);
            end
            rst[1] = 1'b1;
            if (pass == 0) begin
                v[1] = 1'b0; wr[1] = 1'b0;
            end
            @(negedge clk);
            rst[1] = 1'b0; v[1] = 1'b0; wr[1] = 1'b0;
            #1;
            check("abort_stall_after", 1, 32'(stall[1]), 32'd0);
            check("abort_valid_after", 1, 32'(dv[1]), 32'd0);
            check("abort_mis_after", 1, 32'(mis[1]), 32'd0);
            check("abort_dout_after", 1, dout[1], 32'd0);
            p_dv[1] = 1'b0; p_mis[1] = 1'b0; p_chk[1] = 1'b1; p_dout[1] = '0;
            last[1] = '0; known[1] = 1'b1;
            do_op(1, 1'b1, 1'b1, 1'b0, OP_LOAD, 3'b010, 32'h20, 32'd0);
            idle(1);
        end

        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 300; n++) begin
                int unsigned kind;
                logic [31:0] a, d;
                logic [2:0]  ff;
                logic [6:0]  op;
                kind = $urandom_range(0, 9);
                a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
                d = $urandom;
                if (kind <= 3) begin
                    ff = 3'($urandom_range(0, 7));
                    do_op(i, 1'b1, 1'b1, 1'b0, OP_LOAD, ff, a, d);
                end else if (kind <= 6) begin
                    case ($urandom_range(0, 5))
                        0: ff = 3'b000;
                        1: ff = 3'b001;
                        2: ff = 3'b010;
                        3: ff = 3'b011;
                        4: ff = 3'b110;
                        default: ff = 3'b111;
                    endcase
                    do_op(i, 1'b1, 1'b0, 1'b1, OP_STORE, ff, a, d);
                end else if (kind <= 8) begin
                    case ($urandom_range(0, 3))
                        0: op = OP_JAL;
                        1: op = 7'b1100111;
                        2: op = 7'b0110011;
                        default: op = 7'b0010011;
                    endcase
                    do_op(i, 1'b1, 1'b0, 1'b0, op, 3'($urandom_range(0, 7)), a, d);
                end else begin
                    do_op(i, 1'b0, 1'($urandom_range(0, 1)), 1'b0, OP_LOAD, 3'b010, a, d);
                end
            end
            idle(i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
